// File: rtl/iir_allpole_mac.sv
// rtl/iir_allpole_mac.sv - time-multiplexed all-pole IIR section, y[n] = x[n] - sum a_k*y[n-k]
//
// One signed multiplier is shared across all feedback taps. An accepted sample
// walks IDLE -> MAC (one tap per cycle) -> RND -> OUT. In RND the accumulator is
// rounded and saturated, and the result is pushed into the feedback history.
//
// Ports:
//   clk      rising-edge clock
//   i_rst    synchronous reset, active-low
//   i_x      input sample, signed Q1.15
//   i_valid  i_x valid; held with i_x stable until accepted
//   o_ready  block can accept a sample (IDLE only)
//   i_a      packed coefficients, a_k at [k*CW-1:(k-1)*CW], signed Q1.15
//   o_y      output sample, signed Q3.15
//   o_valid  o_y valid
//   i_ready  downstream accepts o_y
//   o_sat    o_y of the current result was clipped
module iir_allpole_mac #(
  parameter int NPOLES = 3,
  parameter int XW     = 16,
  parameter int CW     = 16,
  parameter int YW     = 18,
  parameter int AW     = 40
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [XW-1:0]        i_x,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NPOLES*CW-1:0] i_a,
  output logic [YW-1:0]        o_y,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sat
);

  localparam int KW = $clog2(NPOLES + 1);
  localparam int PW = CW + YW;

  // Saturation bounds of the output, expressed at accumulator width.
  localparam logic signed [AW-1:0] R_MAX = {{(AW-YW+1){1'b0}}, {(YW-1){1'b1}}};
  localparam logic signed [AW-1:0] R_MIN = {{(AW-YW+1){1'b1}}, {(YW-1){1'b0}}};
  // Half an output LSB in Q.30 for round-half-up.
  localparam logic signed [AW-1:0] HALF  = {{(AW-15){1'b0}}, 1'b1, 14'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_RND,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [CW-1:0]  a_q  [NPOLES];
  logic signed [CW-1:0]  a_d  [NPOLES];
  // yh_q[0] holds y[n-1], yh_q[NPOLES-1] holds y[n-NPOLES].
  logic signed [YW-1:0]  yh_q [NPOLES];
  logic signed [YW-1:0]  yh_d [NPOLES];
  logic signed [YW-1:0]  y_q, y_d;
  logic                  sat_q, sat_d;
  // Keeps o_ready low during reset and for the release edge itself.
  logic                  en_q, en_d;

  logic                  accept;
  logic signed [CW-1:0]  coef;
  logic signed [YW-1:0]  yk;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  rnd_sum;
  logic signed [AW-1:0]  rnd_r;
  logic signed [YW-1:0]  y_sat;
  logic                  clip;

  assign o_ready = en_q && (state_q == S_IDLE);
  assign o_valid = (state_q == S_OUT);
  assign o_y     = y_q;
  assign o_sat   = sat_q;
  assign accept  = i_valid && o_ready;

  // Tap operand select for the current k (1-based).
  always_comb begin
    coef = '0;
    yk   = '0;
    for (int i = 0; i < NPOLES; i++) begin
      if (k_q == KW'(i + 1)) begin
        coef = a_q[i];
        yk   = yh_q[i];
      end
    end
  end

  assign prod = coef * yk;

  // Round half up, then clip to the YW-bit signed range.
  always_comb begin
    rnd_sum = acc_q + HALF;
    rnd_r   = rnd_sum >>> 15;
    clip    = 1'b0;
    y_sat   = rnd_r[YW-1:0];
    if (rnd_r > R_MAX) begin
      clip  = 1'b1;
      y_sat = R_MAX[YW-1:0];
    end else if (rnd_r < R_MIN) begin
      clip  = 1'b1;
      y_sat = R_MIN[YW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    yh_d    = yh_q;
    y_d     = y_q;
    sat_d   = sat_q;
    en_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int i = 0; i < NPOLES; i++) begin
            a_d[i] = i_a[i*CW +: CW];
          end
          acc_d   = {{(AW-XW-15){i_x[XW-1]}}, i_x, 15'b0};
          k_d     = KW'(1);
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q - {{(AW-PW){prod[PW-1]}}, prod};
        if (k_q == KW'(NPOLES)) begin
          state_d = S_RND;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_RND: begin
        y_d     = y_sat;
        sat_d   = clip;
        // The clipped value is what feeds back, keeping the loop bounded.
        yh_d[0] = y_sat;
        for (int i = 1; i < NPOLES; i++) begin
          yh_d[i] = yh_q[i-1];
        end
        k_d     = '0;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      en_q    <= 1'b0;
      for (int i = 0; i < NPOLES; i++) begin
        a_q[i]  <= '0;
        yh_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      en_q    <= en_d;
      for (int i = 0; i < NPOLES; i++) begin
        a_q[i]  <= a_d[i];
        yh_q[i] <= yh_d[i];
      end
    end
  end

endmodule

// File: tb/tb_iir_allpole_mac.sv
// tb/tb_iir_allpole_mac.sv - directed self-checking bench for iir_allpole_mac
module tb_iir_allpole_mac;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_x;
  logic        i_valid;
  logic        o_ready;
  logic [47:0] i_a;
  logic [17:0] o_y;
  logic        o_valid;
  logic        i_ready;
  logic        o_sat;

  int checks = 0;
  int errors = 0;

  // a = {a3, a2, a1}
  localparam logic [47:0] A_IMP  = {16'h4000, 16'h2000, 16'hC000};
  localparam logic [47:0] A_SAT  = {16'h0000, 16'h0000, 16'h8000};
  localparam logic [47:0] A_ZERO = 48'h0;
  localparam logic [47:0] A_P1   = {16'h0000, 16'h0000, 16'h0001};
  localparam logic [47:0] A_M1   = {16'h0000, 16'h0000, 16'hFFFF};

  iir_allpole_mac dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_x     (i_x),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .o_y     (o_y),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_x     = '0;
    repeat (2) tick;
    i_rst   = 1'b1;
  endtask

  // Drives one sample, scrambles i_a after acceptance, waits for o_valid.
  // lat is the cycle count from the accept edge to o_valid, -1 on timeout.
  task automatic run_sample(input logic [15:0] x, input logic [47:0] a,
                            output logic [17:0] y, output logic s, output int lat);
    int n;
    n       = 0;
    i_x     = x;
    i_a     = a;
    i_valid = 1'b1;
    while (!o_ready && n < 50) begin
      tick;
      n++;
    end
    if (!o_ready) begin
      i_valid = 1'b0;
      lat     = -1;
      y       = 'x;
      s       = 1'bx;
      return;
    end
    tick;
    i_valid = 1'b0;
    i_x     = 16'h1234;
    i_a     = ~a;
    lat     = 0;
    while (!o_valid && lat < 50) begin
      tick;
      lat++;
    end
    if (!o_valid) lat = -1;
    y = o_y;
    s = o_sat;
  endtask

  task automatic test_reset;
    logic [17:0] y;
    logic        s;
    int          lat;
    i_rst   = 1'b0;
    i_valid = 1'b1;
    i_x     = 16'h4000;
    i_a     = A_IMP;
    repeat (3) tick;
    checks++;
    if (o_valid !== 1'b0 || o_y !== 18'd0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b y=%0d ready=%b expected 0 0 0", o_valid, o_y, o_ready);
    end
    i_rst = 1'b1;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_same_cycle: ready=%b expected 0", o_ready);
    end
    tick;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: ready=%b expected 1", o_ready);
    end
    run_sample(16'h4000, A_IMP, y, s, lat);
    checks++;
    if ($signed(y) !== 16384 || s !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL reset_first_sample: y=%0d sat=%b lat=%0d expected 16384 0 4", $signed(y), s, lat);
    end
  endtask

  task automatic test_impulse(input string tag);
    int          exp_y [4] = '{16384, 8192, 0, -10240};
    logic [17:0] y;
    logic        s;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_sample((i == 0) ? 16'h4000 : 16'h0000, A_IMP, y, s, lat);
      checks++;
      if ($signed(y) !== exp_y[i] || s !== 1'b0 || lat !== 4) begin
        errors++;
        $display("FAIL %s[%0d]: y=%0d sat=%b lat=%0d expected %0d 0 4", tag, i, $signed(y), s, lat, exp_y[i]);
      end
    end
  endtask

  task automatic test_saturation;
    int          exp_y [6] = '{32767, 65534, 98301, 131068, 131071, 131071};
    logic        exp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] y;
    logic        s;
    int          lat;
    do_reset;
    for (int i = 0; i < 6; i++) begin
      run_sample(16'h7FFF, A_SAT, y, s, lat);
      checks++;
      if ($signed(y) !== exp_y[i] || s !== exp_s[i] || lat !== 4) begin
        errors++;
        $display("FAIL saturation[%0d]: y=%0d sat=%b lat=%0d expected %0d %b 4", i, $signed(y), s, lat, exp_y[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_rounding;
    logic [15:0] xs    [4] = '{16'h4000, 16'h0000, 16'h4000, 16'h0000};
    logic [47:0] as    [4] = '{A_ZERO, A_P1, A_ZERO, A_M1};
    int          exp_y [4] = '{16384, 0, 16384, 1};
    logic [17:0] y;
    logic        s;
    int          lat;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      run_sample(xs[i], as[i], y, s, lat);
      checks++;
      if ($signed(y) !== exp_y[i] || s !== 1'b0) begin
        errors++;
        $display("FAIL rounding[%0d]: y=%0d sat=%b expected %0d 0", i, $signed(y), s, exp_y[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [17:0] y;
    logic        s;
    int          lat;
    do_reset;
    i_ready = 1'b0;
    run_sample(16'h4000, A_ZERO, y, s, lat);
    checks++;
    if ($signed(y) !== 16384 || lat !== 4) begin
      errors++;
      $display("FAIL bp_first: y=%0d lat=%0d expected 16384 4", $signed(y), lat);
    end
    i_x     = 16'h2000;
    i_a     = A_ZERO;
    i_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (o_valid !== 1'b1 || $signed(o_y) !== 16384 || o_sat !== 1'b0 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b y=%0d sat=%b ready=%b expected 1 16384 0 0", i, o_valid, $signed(o_y), o_sat, o_ready);
      end
    end
    i_ready = 1'b1;
    tick;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0 1", o_valid, o_ready);
    end
    tick;
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: ready=%b expected 0", o_ready);
    end
    lat = 0;
    while (!o_valid && lat < 50) begin
      tick;
      lat++;
    end
    checks++;
    if ($signed(o_y) !== 8192 || o_valid !== 1'b1 || lat !== 4) begin
      errors++;
      $display("FAIL bp_second: y=%0d valid=%b lat=%0d expected 8192 1 4", $signed(o_y), o_valid, lat);
    end
  endtask

  task automatic test_mid_reset;
    logic [17:0] y;
    logic        s;
    int          lat;
    int          n;
    int          seen;
    do_reset;
    run_sample(16'h4000, A_IMP, y, s, lat);
    run_sample(16'h0000, A_IMP, y, s, lat);
    i_x     = 16'h4000;
    i_a     = A_IMP;
    i_valid = 1'b1;
    n       = 0;
    while (!o_ready && n < 50) begin
      tick;
      n++;
    end
    tick;
    i_valid = 1'b0;
    tick;
    i_rst = 1'b0;
    tick;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: valid=%b ready=%b expected 0 0", o_valid, o_ready);
    end
    i_rst = 1'b1;
    seen  = 0;
    repeat (10) begin
      tick;
      if (o_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_output: valid cycles=%0d expected 0", seen);
    end
    test_impulse("mid_reset_impulse");
  endtask

  initial begin
    i_rst   = 1'b0;
    i_x     = '0;
    i_valid = 1'b0;
    i_a     = '0;
    i_ready = 1'b1;
    test_reset;
    do_reset;
    test_impulse("impulse");
    test_saturation;
    test_rounding;
    test_backpressure;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
